// File: rtl/debounce_toggle_gen_pkg.sv
// Shared types and defaults for the debounced button toggle-pulse generator.
package debounce_toggle_gen_pkg;

    // Debounce FSM states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned PRESS_COUNT_W       = 8;

    // Debounced level implied by a state: high once a press has been accepted.
    function automatic logic level_of(input state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

    // A qualification window is open in either wait state.
    function automatic logic busy_of(input state_t s);
        return (s == PRESS_WAIT) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level.
module sync_ff_chain #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    // Shift the raw input in at bit 0; the oldest sample sits at the top bit.
    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], d_in};
    end

    // Synchronizer register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/debounce_toggle_gen.sv
// Debounces a raw button and emits one registered toggle request per
// accepted press, with a wrapping 8-bit count of emitted requests.
module debounce_toggle_gen
    import debounce_toggle_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       en,
    output logic       t_pulse,
    output logic       btn_level,
    output logic [7:0] press_count,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                     btn_sync;

    state_t                   state_q,       state_d;
    logic [CNT_W-1:0]         cnt_q,         cnt_d;
    logic                     t_pulse_q,     t_pulse_d;
    logic                     btn_level_q,   btn_level_d;
    logic                     busy_q,        busy_d;
    logic [PRESS_COUNT_W-1:0] press_count_q, press_count_d;

    sync_ff_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (btn_in),
        .q_out (btn_sync)
    );

    // Next state, window counter, pulse request and registered output values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        t_pulse_d     = 1'b0;
        press_count_d = press_count_q;

        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    t_pulse_d = en;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (t_pulse_d) begin
            press_count_d = press_count_q + PRESS_COUNT_W'(1);
        end

        // Level and busy are registered from the next state so they change
        // in the same cycle as the state they describe.
        btn_level_d = level_of(state_d);
        busy_d      = busy_of(state_d);
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            t_pulse_q     <= 1'b0;
            btn_level_q   <= 1'b0;
            busy_q        <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            t_pulse_q     <= t_pulse_d;
            btn_level_q   <= btn_level_d;
            busy_q        <= busy_d;
            press_count_q <= press_count_d;
        end
    end

    assign t_pulse     = t_pulse_q;
    assign btn_level   = btn_level_q;
    assign busy        = busy_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// Directed self-checking bench for debounce_toggle_gen (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_debounce_toggle_gen;

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       en;
    logic       t_pulse;
    logic       btn_level;
    logic [7:0] press_count;
    logic       busy;

    int n_tests;
    int n_fail;
    int pulse_cnt;

    debounce_toggle_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .en          (en),
        .t_pulse     (t_pulse),
        .btn_level   (btn_level),
        .press_count (press_count),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count emitted pulses on the falling edge, away from the active edge.
    initial pulse_cnt = 0;
    always @(negedge clk) begin
        if (t_pulse === 1'b1) pulse_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".t_pulse"},     32'(t_pulse),     32'd0);
        check({tag, ".btn_level"},   32'(btn_level),   32'd0);
        check({tag, ".press_count"}, 32'(press_count), 32'd0);
        check({tag, ".busy"},        32'(busy),        32'd0);
    endtask

    // One clean press and release, 7 edges each, enough to settle back in IDLE.
    task automatic clean_press();
        btn_in = 1'b1;
        ticks(7);
        btn_in = 1'b0;
        ticks(7);
    endtask

    int base_pulses;
    int busy_cycles;
    int window_pulses;
    logic [7:0] bounce_pat;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        btn_in  = 1'b0;
        en      = 1'b1;

        // Reset state
        ticks(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        ticks(3);
        check_all_zero("post_reset_idle");

        // Clean press: btn high before edge 0; pulse only after edge 6
        btn_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("press.t_pulse[%0d]", k),   32'(t_pulse),     (k == 6) ? 32'd1 : 32'd0);
            check($sformatf("press.level[%0d]", k),     32'(btn_level),   (k >= 6) ? 32'd1 : 32'd0);
            check($sformatf("press.busy[%0d]", k),      32'(busy),        (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
            check($sformatf("press.count[%0d]", k),     32'(press_count), (k >= 6) ? 32'd1 : 32'd0);
        end
        // Clean release: level stays up through RELEASE_WAIT, drops after edge 6
        btn_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("release.level[%0d]", k), 32'(btn_level), (k < 6) ? 32'd1 : 32'd0);
            check($sformatf("release.t_pulse[%0d]", k), 32'(t_pulse), 32'd0);
        end
        check("press.pulses", 32'(pulse_cnt), 32'd1);

        // Glitch: 2 cycles high -> PRESS_WAIT for 2 cycles, then IDLE
        busy_cycles = 0;
        btn_in = 1'b1;
        tick();
        if (busy === 1'b1) busy_cycles++;
        tick();
        if (busy === 1'b1) busy_cycles++;
        btn_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            check($sformatf("glitch.t_pulse[%0d]", k), 32'(t_pulse), 32'd0);
        end
        check("glitch.busy_cycles", 32'(busy_cycles), 32'd2);
        check("glitch.count",       32'(press_count), 32'd1);
        check("glitch.level",       32'(btn_level),   32'd0);
        check("glitch.busy_end",    32'(busy),        32'd0);
        check("glitch.pulses",      32'(pulse_cnt),   32'd1);

        // Bouncy press and release: exactly one pulse
        base_pulses = pulse_cnt;
        bounce_pat = 8'b0001_0101;
        for (int k = 0; k < 6; k++) begin
            btn_in = bounce_pat[k];
            tick();
        end
        btn_in = 1'b1;
        ticks(10);
        check("bounce.level_high", 32'(btn_level), 32'd1);
        btn_in = 1'b0;
        tick();
        btn_in = 1'b1;
        tick();
        btn_in = 1'b0;
        tick();
        ticks(12);
        check("bounce.pulses", 32'(pulse_cnt - base_pulses), 32'd1);
        check("bounce.count",  32'(press_count), 32'd2);
        check("bounce.level",  32'(btn_level),   32'd0);
        check("bounce.busy",   32'(busy),        32'd0);

        // Enable gating
        base_pulses = pulse_cnt;
        en = 1'b0;
        btn_in = 1'b1;
        ticks(10);
        check("gate.level",  32'(btn_level), 32'd1);
        check("gate.count",  32'(press_count), 32'd2);
        check("gate.pulses", 32'(pulse_cnt - base_pulses), 32'd0);
        btn_in = 1'b0;
        ticks(10);
        check("gate.level_low", 32'(btn_level), 32'd0);
        en = 1'b1;
        clean_press();
        check("gate.count_en",  32'(press_count), 32'd3);
        check("gate.pulses_en", 32'(pulse_cnt - base_pulses), 32'd1);

        // Asynchronous reset mid-cycle clears outputs immediately
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        rst_n = 1'b1;
        ticks(2);

        // Wrap: 256 presses from zero
        base_pulses = pulse_cnt;
        for (int p = 0; p < 255; p++) clean_press();
        check("wrap.count_255", 32'(press_count), 32'd255);
        clean_press();
        check("wrap.count_0",   32'(press_count), 32'd0);
        check("wrap.pulses",    32'(pulse_cnt - base_pulses), 32'd256);

        // Reset mid-window: asserted before edge 4, released before edge 6
        base_pulses = pulse_cnt;
        btn_in = 1'b1;
        ticks(4);
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst.assert");
        window_pulses = 0;
        for (int k = 4; k < 6; k++) begin
            tick();
            check_all_zero($sformatf("midrst.hold[%0d]", k));
        end
        rst_n = 1'b1;
        for (int k = 6; k < 15; k++) begin
            tick();
            if (t_pulse === 1'b1) window_pulses++;
            check($sformatf("midrst.t_pulse[%0d]", k), 32'(t_pulse), (k == 12) ? 32'd1 : 32'd0);
        end
        check("midrst.window_pulses", 32'(window_pulses), 32'd1);
        check("midrst.count",  32'(press_count), 32'd1);
        check("midrst.pulses", 32'(pulse_cnt - base_pulses), 32'd1);
        btn_in = 1'b0;
        ticks(8);
        check("midrst.level_end", 32'(btn_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_toggle_gen.md
DEBOUNCE_TOGGLE_GEN -- requirements
Module: debounce_toggle_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the synchronizer depth for btn_in; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized samples required to accept a level change; legal minimum 2.
REQ-003 Parameter CNT_W, default $clog2(DEBOUNCE_CYCLES), is the debounce counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_in  input  1  raw asynchronous, bouncing button level; active-high.
REQ-007 en  input  1  synchronous enable for toggle-pulse generation.
REQ-008 t_pulse  output  1  registered single-cycle toggle request; drives the t input of the downstream toggle flip-flop.
REQ-009 btn_level  output  1  registered debounced button level.
REQ-010 press_count  output  8  registered count of generated t_pulse events.
REQ-011 busy  output  1  high while a debounce qualification window is in progress.

Function
REQ-012 btn_in SHALL pass through a SYNC_STAGES-deep flip-flop chain; only the last stage (btn_sync) feeds the FSM.
REQ-013 FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE: btn_sync=1 -> PRESS_WAIT, counter cleared to 0; else stay.
REQ-015 PRESS_WAIT: btn_sync=0 -> IDLE (glitch rejected, no pulse); btn_sync=1 with counter=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-016 PRESSED: btn_sync=0 -> RELEASE_WAIT, counter cleared; else stay.
REQ-017 RELEASE_WAIT: btn_sync=1 -> PRESSED (release bounce rejected, no pulse); btn_sync=0 with counter=DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-018 t_pulse SHALL be high for exactly one cycle, the cycle in which the state first reads PRESSED after PRESS_WAIT, and only if en=1 at the transition edge.
REQ-019 Latency: with btn_in high and stable before clock edge 0, t_pulse SHALL be high in the cycle following edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-020 RELEASE_WAIT -> PRESSED SHALL NOT generate t_pulse; one physical press produces at most one pulse.
REQ-021 btn_level SHALL be 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-022 busy SHALL be 1 in PRESS_WAIT and RELEASE_WAIT, 0 otherwise.
REQ-023 press_count SHALL increment in the same edge that sets t_pulse, wrapping 255 -> 0.
REQ-024 en=0 SHALL suppress t_pulse and press_count increment only; debounce FSM, btn_level and busy continue to operate.
REQ-025 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around inside a window.

Reset
REQ-026 rst_n=0 SHALL immediately force: synchronizer stages 0, state IDLE, counter 0, t_pulse 0, btn_level 0, press_count 0, busy 0.
REQ-027 Reset asserted mid-window (any state) SHALL discard the window; no t_pulse on or after deassertion until a full new qualification completes.
REQ-028 After rst_n deassertion with btn_in already high, a pulse SHALL be generated after the normal REQ-019 latency.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef/encoding (2-bit) and default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_ff_chain, parameterized by depth, with clk/rst_n reset to 0.
REQ-031 All outputs SHALL be driven directly from flip-flops; no combinational path from btn_in or en to any output.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-032 Clean press: btn_in 0->1 before edge 0, held -> t_pulse high only in cycle after edge 6, press_count 0->1, btn_level 1 from same cycle.
REQ-033 Glitch: btn_in high for 2 cycles then low -> no t_pulse, press_count stays 0, busy high for <=2 cycles, state returns IDLE.
REQ-034 Bouncy press/release: btn_in toggles every cycle for 6 cycles then stable high 10 cycles, then bounces low/high 3 cycles then stable low -> exactly one t_pulse, press_count=1, btn_level returns 0.
REQ-035 Enable gating: en=0 during a clean press -> btn_level rises, t_pulse never high, press_count unchanged; next press with en=1 -> one pulse.
REQ-036 Wrap: 256 clean presses with en=1 -> press_count reads 0, 256 t_pulses observed.
REQ-037 Reset mid-window: rst_n low at edge 4 of a press, released at edge 6, btn_in held high -> all outputs 0 during reset, t_pulse high one cycle, 6 cycles after the first post-release edge.
